// File: rtl/fsm_tick_counter.sv
// Counts active-low ticks from an upstream 2-bit down-counter FSM, modulo TC+1.
// Define FSM_TICK_SEQ_CHECK_EN to build the sticky upstream sequence checker (seq_err).
module fsm_tick_counter #(
  parameter int WIDTH = 8,
  parameter int TC    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       state_in,
  input  logic             y_in,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             seq_err
);

  localparam logic [WIDTH-1:0] TC_V = WIDTH'(TC);

  logic             y_prev_q;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             tick;

  // Falling edge of y_in; a long low phase yields a single tick.
  assign tick = y_prev_q & ~y_in;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (tick && en) begin
      if (count_q >= TC_V) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_prev_q <= 1'b1;
      count_q  <= '0;
      wrap_q   <= 1'b0;
    end else begin
      y_prev_q <= y_in;
      count_q  <= count_d;
      wrap_q   <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

`ifdef FSM_TICK_SEQ_CHECK_EN
  logic [1:0] st_prev_q;
  logic       chk_valid_q;
  logic       seq_err_q;
  logic [1:0] st_dec;
  logic       viol;

  assign st_dec = st_prev_q - 2'd1;
  // Holding the state is legal; only a step other than -1 (mod 4) is flagged.
  assign viol = (chk_valid_q && (state_in != st_prev_q) && (state_in != st_dec))
             || (y_in != (state_in != 2'b00));

  always_ff @(posedge clk) begin
    if (rst) begin
      st_prev_q   <= 2'b11;
      chk_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      st_prev_q   <= state_in;
      chk_valid_q <= ~clr;
      seq_err_q   <= clr ? 1'b0 : (seq_err_q | viol);
    end
  end

  assign seq_err = seq_err_q;
`else
  logic unused_state;
  assign unused_state = ^state_in;
  assign seq_err      = 1'b0;
`endif

endmodule
